// File: rtl/laneswitch_pkg.sv
// laneswitch_pkg: shared state encodings, lane select constants and default parameters
// for the lane switch ownership controller.
package laneswitch_pkg;
    typedef enum logic [2:0] {
        ST_OWN0   = 3'd0,
        ST_DRAIN0 = 3'd1,
        ST_OWN1   = 3'd2,
        ST_DRAIN1 = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;
    localparam logic LANE0_SEL = 1'b0;
    localparam logic LANE1_SEL = 1'b1;
    localparam int QUIET_CYCLES_DEF   = 2;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    localparam int CNT_WIDTH_DEF      = 16;
endpackage

// File: rtl/laneswitch_ctrl_if.sv
// laneswitch_ctrl_if: lane handshakes and memory status seen by the ownership controller.
// Optional LASWCTRL_STATS_EN adds the switch_count/max_drain statistics outputs.
interface laneswitch_ctrl_if #(parameter int CNT_WIDTH = 16);
    logic       lane0_release;
    logic       lane0_release_ack;
    logic       lane0_grant;
    logic       lane1_release;
    logic       lane1_release_ack;
    logic       lane1_grant;
    logic       switch;
    logic       mem_active;
    logic       mem_fault;
    logic       err;
    logic [2:0] state_o;
`ifdef LASWCTRL_STATS_EN
    logic [CNT_WIDTH-1:0] switch_count;
    logic [CNT_WIDTH-1:0] max_drain;
`endif
    modport master (
        input  lane0_release, lane1_release, mem_active, mem_fault,
        output lane0_release_ack, lane0_grant, lane1_release_ack, lane1_grant, switch, err, state_o
`ifdef LASWCTRL_STATS_EN
        , output switch_count, max_drain
`endif
    );
    modport slave (
        output lane0_release, lane1_release, mem_active, mem_fault,
        input  lane0_release_ack, lane0_grant, lane1_release_ack, lane1_grant, switch, err, state_o
`ifdef LASWCTRL_STATS_EN
        , input switch_count, max_drain
`endif
    );
endinterface

// File: rtl/laneswitch_drain_cnt.sv
// laneswitch_drain_cnt: saturating quiet/elapsed counters shared by both drain states.
// Optional LASWCTRL_STATS_EN exposes the elapsed count.
module laneswitch_drain_cnt import laneswitch_pkg::*; #(
    parameter int QUIET_CYCLES   = QUIET_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic active,
    output logic quiet_done,
    output logic timeout
`ifdef LASWCTRL_STATS_EN
    , output logic [CNT_WIDTH-1:0] elapsed
`endif
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
    localparam logic [CNT_WIDTH-1:0] QUIET_LAST   = CNT_WIDTH'(QUIET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    logic [CNT_WIDTH-1:0] quiet_q, quiet_d, elapsed_q, elapsed_d;
    always_comb begin
        quiet_d   = clr ? '0 : !en ? quiet_q : active ? '0 :
                    (quiet_q == CNT_MAX) ? quiet_q : quiet_q + 1'b1;
        elapsed_d = clr ? '0 : (!en || elapsed_q == CNT_MAX) ? elapsed_q : elapsed_q + 1'b1;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quiet_q   <= '0;
            elapsed_q <= '0;
        end else begin
            quiet_q   <= quiet_d;
            elapsed_q <= elapsed_d;
        end
    end
    // Both flags look at the count this edge will produce, so the FSM moves on the reaching edge.
    assign quiet_done = en && !active && quiet_q >= QUIET_LAST;
    assign timeout    = en && elapsed_q >= TIMEOUT_LAST;
`ifdef LASWCTRL_STATS_EN
    assign elapsed = elapsed_q;
`endif
endmodule

// File: rtl/laneswitch_ctrl.sv
// laneswitch_ctrl: ping-pong memory ownership controller driving the lane switch select.
// Optional LASWCTRL_STATS_EN adds saturating switch_count and max_drain statistics.
module laneswitch_ctrl import laneswitch_pkg::*; #(
    parameter int QUIET_CYCLES   = QUIET_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input logic clk,
    input logic reset,
    laneswitch_ctrl_if.master bus
);
    state_e state_q, state_d;
    logic switch_q, switch_d, grant0_q, grant0_d, grant1_q, grant1_d;
    logic ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d;
    logic draining, quiet_done, timeout;
`ifdef LASWCTRL_STATS_EN
    logic [CNT_WIDTH-1:0] elapsed, switch_count_q, switch_count_d, max_drain_q, max_drain_d;
`endif
    assign draining = state_q == ST_DRAIN0 || state_q == ST_DRAIN1;
    laneswitch_drain_cnt #(
        .QUIET_CYCLES(QUIET_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_WIDTH(CNT_WIDTH)
    ) u_drain_cnt (
        .clk(clk), .reset(reset), .clr(!draining), .en(draining), .active(bus.mem_active),
        .quiet_done(quiet_done), .timeout(timeout)
`ifdef LASWCTRL_STATS_EN
        , .elapsed(elapsed)
`endif
    );
    always_comb begin
        state_d  = state_q;
        switch_d = switch_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        case (state_q)
            ST_OWN0: if (bus.lane0_release) begin
                state_d = ST_DRAIN0;
                ack0_d  = 1'b1;
            end
            ST_DRAIN0: if (bus.mem_fault || timeout) state_d = ST_ERROR;
                else if (quiet_done) begin
                    state_d  = ST_OWN1;
                    switch_d = LANE1_SEL;
                end
            ST_OWN1: if (bus.lane1_release) begin
                state_d = ST_DRAIN1;
                ack1_d  = 1'b1;
            end
            ST_DRAIN1: if (bus.mem_fault || timeout) state_d = ST_ERROR;
                else if (quiet_done) begin
                    state_d  = ST_OWN0;
                    switch_d = LANE0_SEL;
                end
            default: state_d = ST_ERROR;
        endcase
        err_d    = state_d == ST_ERROR;
        grant0_d = state_d == ST_OWN0;
        grant1_d = state_d == ST_OWN1;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_OWN0;
            switch_q <= LANE0_SEL;
            grant0_q <= 1'b1;
            grant1_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            switch_q <= switch_d;
            grant0_q <= grant0_d;
            grant1_q <= grant1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err_q    <= err_d;
        end
    end
`ifdef LASWCTRL_STATS_EN
    always_comb begin
        switch_count_d = (switch_d != switch_q && switch_count_q != '1) ? switch_count_q + 1'b1
                                                                         : switch_count_q;
        max_drain_d    = elapsed > max_drain_q ? elapsed : max_drain_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            switch_count_q <= '0;
            max_drain_q    <= '0;
        end else begin
            switch_count_q <= switch_count_d;
            max_drain_q    <= max_drain_d;
        end
    end
    assign bus.switch_count = switch_count_q;
    assign bus.max_drain    = max_drain_q;
`endif
    assign bus.switch            = switch_q;
    assign bus.lane0_grant       = grant0_q;
    assign bus.lane1_grant       = grant1_q;
    assign bus.lane0_release_ack = ack0_q;
    assign bus.lane1_release_ack = ack1_q;
    assign bus.err               = err_q;
    assign bus.state_o           = state_q;
endmodule

// File: tb/tb_laneswitch_ctrl.sv
// tb_laneswitch_ctrl: directed plus random checks of laneswitch_ctrl against a lane-ownership model.
module tb_laneswitch_ctrl;
    localparam int Q  = 2;
    localparam int TO = 8;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    laneswitch_ctrl_if #(.CNT_WIDTH(16)) bus ();
    laneswitch_ctrl #(.QUIET_CYCLES(Q), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    int errors = 0;
    int checks = 0;
    // Model: which lane owns the memory, whether a handoff is draining, and the sticky error.
    int m_owner, m_drain, m_err, m_quiet, m_el, m_toggles;
    int m_ack [2];
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_owner = 0; m_drain = 0; m_err = 0; m_quiet = 0; m_el = 0; m_toggles = 0;
        m_ack[0] = 0; m_ack[1] = 0;
    endtask
    task automatic step(input logic r0, input logic r1, input logic act, input logic flt);
        logic [1:0] rel;
        rel = {r1, r0};
        m_ack[0] = 0;
        m_ack[1] = 0;
        if (m_err != 0) return;
        if (m_drain == 0) begin
            if (rel[m_owner]) begin
                m_drain = 1; m_ack[m_owner] = 1; m_quiet = 0; m_el = 0;
            end
        end else begin
            m_el++;
            m_quiet = act ? 0 : m_quiet + 1;
            if (flt || m_el >= TO) m_err = 1;
            else if (m_quiet >= Q) begin
                m_owner = 1 - m_owner; m_drain = 0; m_toggles++;
            end
        end
    endtask
    task automatic compare();
        check("state_o", 32'(bus.state_o), m_err != 0 ? 4 : 2 * m_owner + m_drain);
        check("switch", 32'(bus.switch), m_owner);
        check("grant0", 32'(bus.lane0_grant), 32'(m_err == 0 && m_drain == 0 && m_owner == 0));
        check("grant1", 32'(bus.lane1_grant), 32'(m_err == 0 && m_drain == 0 && m_owner == 1));
        check("ack0", 32'(bus.lane0_release_ack), m_ack[0]);
        check("ack1", 32'(bus.lane1_release_ack), m_ack[1]);
        check("err", 32'(bus.err), m_err);
`ifdef LASWCTRL_STATS_EN
        check("switch_count", 32'(bus.switch_count), m_toggles);
`endif
    endtask
    task automatic cycle(input logic r0, input logic r1, input logic act, input logic flt);
        bus.lane0_release = r0;
        bus.lane1_release = r1;
        bus.mem_active    = act;
        bus.mem_fault     = flt;
        @(posedge clk);
        step(r0, r1, act, flt);
        #1 compare();
        @(negedge clk);
    endtask
    task automatic do_reset(input int n);
        #2 reset = 1'b0;
        bus.lane0_release = 1'b0;
        bus.lane1_release = 1'b0;
        bus.mem_active    = 1'b0;
        bus.mem_fault     = 1'b0;
        model_reset();
        #1 compare();
        repeat (n) begin
            @(posedge clk);
            #1 compare();
        end
        @(negedge clk);
        reset = 1'b1;
    endtask
    initial begin
        bus.lane0_release = 1'b0;
        bus.lane1_release = 1'b0;
        bus.mem_active    = 1'b0;
        bus.mem_fault     = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1 compare();
        end
        @(negedge clk);
        reset = 1'b1;
        // Clean handoff 0 -> 1.
        cycle(1, 0, 0, 0);
        check("handoff_ack0", 32'(bus.lane0_release_ack), 1);
        cycle(0, 0, 0, 0);
        check("handoff_grant1_early", 32'(bus.lane1_grant), 0);
        cycle(0, 0, 0, 0);
        check("handoff_switch", 32'(bus.switch), 1);
        check("handoff_state", 32'(bus.state_o), 2);
        // Busy drain 1 -> 0 with a quiet blip that must not count.
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        check("busy_grant0_early", 32'(bus.lane0_grant), 0);
        cycle(0, 0, 0, 0);
        check("roundtrip_grant0", 32'(bus.lane0_grant), 1);
        check("roundtrip_switch", 32'(bus.switch), 0);
        // Timeout with memory held busy.
        cycle(1, 0, 1, 0);
        repeat (TO - 1) cycle(0, 0, 1, 0);
        check("timeout_err_early", 32'(bus.err), 0);
        cycle(0, 0, 1, 0);
        check("timeout_err", 32'(bus.err), 1);
        repeat (3) cycle(1, 1, 0, 0);
        check("timeout_sticky_state", 32'(bus.state_o), 4);
        do_reset(2);
        // Fault during DRAIN1.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 1);
        check("fault_state", 32'(bus.state_o), 4);
        check("fault_switch", 32'(bus.switch), 1);
        do_reset(1);
        // Reset asserted mid-drain.
        cycle(1, 0, 1, 0);
        cycle(0, 0, 1, 0);
        do_reset(0);
        check("midreset_state", 32'(bus.state_o), 0);
        check("midreset_grant0", 32'(bus.lane0_grant), 1);
        for (int i = 0; i < 800; i++) begin
            if (m_err != 0 && $urandom_range(0, 3) == 0) do_reset(1);
            else cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
                       $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 3);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/laneswitch_ctrl.md
Name: laneswitch_ctrl

Overview:
Ownership controller that drives the `switch` select of a two-lane memory lane switch, which muxes lane 0 or lane 1 onto a shared 2-port memory. It gives the memory to one lane at a time and accepts a release handshake from the owning lane. It waits for the memory ports to go quiet, then toggles `switch` and grants the other lane. Typical use is a ping-pong handoff between a producer task (lane 0) and a consumer task (lane 1).

Parameters:
- QUIET_CYCLES, 2: consecutive cycles with `mem_active` low needed before the switch toggles; minimum 1.
- TIMEOUT_CYCLES, 1024: maximum cycles allowed in a drain state before entering ERROR; minimum QUIET_CYCLES+1.
- CNT_WIDTH, 16: width of the internal drain counter and of the stats counter; must hold TIMEOUT_CYCLES.

Ports:
- clk, input, 1: single clock.
- reset, input, 1: asynchronous, active-low reset.
- lane0_release, input, 1: lane 0 asks to give up the memory; held high until lane0_release_ack.
- lane0_release_ack, output, 1: one-cycle pulse acknowledging lane 0's release.
- lane0_grant, output, 1: lane 0 owns the memory.
- lane1_release, input, 1: same as lane0_release, for lane 1.
- lane1_release_ack, output, 1: same as lane0_release_ack, for lane 1.
- lane1_grant, output, 1: lane 1 owns the memory.
- switch, output, 1: lane select to the lane switch; 0 = lane 0, 1 = lane 1.
- mem_active, input, 1: `active` from the lane switch (any memory chip-enable high).
- mem_fault, input, 1: `fault` from the lane switch.
- err, output, 1: sticky error flag.
- state_o, output, 3: current FSM state, for debug.

Behaviour:
- Reset values while reset is low: state OWN0, switch=0, lane0_grant=1, lane1_grant=0, both acks 0, err=0, counter 0. Deasserting reset mid-operation always restarts in OWN0.
- All outputs are registered.
- States and encodings: OWN0=0, DRAIN0=1, OWN1=2, DRAIN1=3, ERROR=4.
- OWN0:
  - lane0_release=1 moves to DRAIN0 at the next edge.
  - At that same edge lane0_grant goes to 0 and lane0_release_ack pulses for exactly one cycle; the counter clears.
  - lane1_release is ignored in this state.
- DRAIN0:
  - The quiet count increments on each cycle with mem_active=0 and resets to 0 on any cycle with mem_active=1.
  - A separate elapsed count increments every cycle.
  - When the quiet count reaches QUIET_CYCLES: move to OWN1; switch goes to 1 and lane1_grant to 1 at the same edge.
  - Minimum release-to-grant latency is therefore 1+QUIET_CYCLES cycles.
- OWN1 and DRAIN1 mirror OWN0 and DRAIN0, with lanes swapped and switch returning to 0.
- switch changes only on a DRAIN→OWN edge. Grants are never both high; both are 0 during DRAIN and ERROR.
- A lane that keeps release high after its ack is not re-acknowledged until it owns the memory again. The ack pulses exactly once per ownership period.
- Error entry (ERROR takes priority over completing the switch in the same cycle):
  - mem_fault=1 sampled in any DRAIN state.
  - Elapsed count reaching TIMEOUT_CYCLES in any DRAIN state.
- mem_fault in OWN states is ignored; the lane switch flags normal lane-1 traffic as a fault.
- ERROR: err=1, both grants 0, switch holds its last value, acks 0. Only reset exits ERROR.
- Counter widths: CNT_WIDTH unsigned. Counters saturate and never wrap.

Optional Feature:
- Macro: LASWCTRL_STATS_EN.
- When defined:
  - Adds output switch_count [CNT_WIDTH-1:0], incremented on every switch toggle and saturating at all-ones.
  - Adds output max_drain [CNT_WIDTH-1:0], holding the largest elapsed drain length seen.
  - Both reset to 0.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package laneswitch_pkg holds:
  - the state enum and its encodings;
  - constant LANE0_SEL=1'b0 and LANE1_SEL=1'b1;
  - the default parameter values.
- One natural sub-module, laneswitch_drain_cnt: the quiet and elapsed counters with saturation, clear, quiet_done and timeout outputs. It is instantiated once and shared by both drain states.

Test Plan:
- Reset and idle: hold reset low 3 cycles, then release → switch=0, lane0_grant=1, lane1_grant=0, err=0, state_o=0.
- Clean handoff: QUIET_CYCLES=2, pulse lane0_release high with mem_active=0 → ack pulses on cycle 1; switch=1 and lane1_grant=1 at cycle 3; state_o=2.
- Busy drain: mem_active=1 for 5 cycles after release, then 0 → grant1 rises 2 cycles after mem_active falls; the quiet count resets on any mid-drain active blip.
- Round trip: 0→1→0 handoff → switch returns to 0 and lane0_grant=1; with the STATS macro defined, switch_count=2.
- Timeout: TIMEOUT_CYCLES=8 with mem_active held at 1 → err=1 at cycle 8 of the drain; both grants 0; further releases have no effect until reset.
- Fault and mid-drain reset: mem_fault=1 during DRAIN1 → ERROR with switch still 1. Separately, reset asserted in DRAIN0 → immediate OWN0 values.
